hash_lookup: RTL and testbench

Lookup stage that sits directly downstream of the two-table `hashing` store. It accepts a 32-bit key over a valid/ready handshake and computes the same two bucket indices the store uses. It then probes table 1 and then table 2 through their combinational read ports, and returns hit / table / index over a second valid/ready handshake. Running lookup and hit counters are kept for debug.

---
 rtl/hash_lookup.sv | 95 +++++++++
 tb/tb_hash_lookup.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hash_lookup.sv
// hash_lookup: probes two hash tables for a key and returns hit/table/index over valid/ready
module hash_lookup #(
  parameter int TABLE_SIZE = 20,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_key,
  output logic [$clog2(TABLE_SIZE)-1:0] t1_addr,
  input  logic                          t1_filled,
  input  logic [31:0]                   t1_data,
  output logic [$clog2(TABLE_SIZE)-1:0] t2_addr,
  input  logic                          t2_filled,
  input  logic [31:0]                   t2_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_key,
  output logic                          out_hit,
  output logic                          out_table,
  output logic [$clog2(TABLE_SIZE)-1:0] out_index,
  output logic [CNT_W-1:0]              lookup_cnt,
  output logic [CNT_W-1:0]              hit_cnt
);
  localparam int IW = $clog2(TABLE_SIZE);
  typedef enum logic [2:0] {IDLE, IDX, P1, P2, RESP} state_t;
  state_t           r_state;
  logic [31:0]      r_key;
  logic [IW-1:0]    r_a1, r_a2, r_idx;
  logic             r_hit, r_tab;
  logic [CNT_W-1:0] r_lcnt, r_hcnt;
  logic [31:0]      w_q;
  logic [IW-1:0]    w_i1, w_i2;
  logic             w_h1, w_h2;
  assign w_q  = r_key / 32'(TABLE_SIZE);
  assign w_i1 = IW'(r_key % 32'(TABLE_SIZE));
  assign w_i2 = IW'(w_q % 32'(TABLE_SIZE));
  assign w_h1 = t1_filled && (t1_data == r_key);
  assign w_h2 = t2_filled && (t2_data == r_key);
  assign in_ready   = r_state == IDLE;
  assign out_valid  = r_state == RESP;
  assign t1_addr    = r_a1;
  assign t2_addr    = r_a2;
  assign out_key    = r_key;
  assign out_hit    = r_hit;
  assign out_table  = r_tab;
  assign out_index  = r_idx;
  assign lookup_cnt = r_lcnt;
  assign hit_cnt    = r_hcnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_a1    <= '0;
      r_a2    <= '0;
      r_idx   <= '0;
      r_hit   <= 1'b0;
      r_tab   <= 1'b0;
      r_lcnt  <= '0;
      r_hcnt  <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_key   <= in_key;
          r_state <= IDX;
        end
        IDX: begin
          r_a1    <= w_i1;
          r_a2    <= w_i2;
          r_state <= P1;
        end
        P1: if (w_h1) begin
          r_hit   <= 1'b1;
          r_tab   <= 1'b0;
          r_idx   <= r_a1;
          r_state <= RESP;
        end else r_state <= P2;
        P2: begin
          r_hit   <= w_h2;
          r_tab   <= w_h2;
          r_idx   <= w_h2 ? r_a2 : '0;
          r_state <= RESP;
        end
        RESP: if (out_ready) begin
          // counters stick at all-ones rather than wrapping
          r_lcnt  <= r_lcnt + CNT_W'(r_lcnt != '1);
          r_hcnt  <= r_hcnt + CNT_W'(r_hit && (r_hcnt != '1));
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hash_lookup.sv
// tb_hash_lookup: directed lookups against a behavioural table model checked every cycle
module tb_hash_lookup;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [31:0] in_key = 0;
  logic        in_ready, out_valid, out_hit, out_table, t1_filled, t2_filled;
  logic [4:0]  t1_addr, t2_addr, out_index;
  logic [31:0] t1_data, t2_data, out_key;
  logic [15:0] lookup_cnt, hit_cnt;
  logic [31:0] t1m [0:31];
  logic [31:0] t2m [0:31];
  bit          t1f [0:31];
  bit          t2f [0:31];
  int          total = 0, bad = 0;
  bit          chk_on = 0;

  always #5 clk = ~clk;

  assign t1_filled = t1f[t1_addr];
  assign t1_data   = t1m[t1_addr];
  assign t2_filled = t2f[t2_addr];
  assign t2_data   = t2m[t2_addr];

  hash_lookup dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
    .t1_addr(t1_addr), .t1_filled(t1_filled), .t1_data(t1_data),
    .t2_addr(t2_addr), .t2_filled(t2_filled), .t2_data(t2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key), .out_hit(out_hit),
    .out_table(out_table), .out_index(out_index), .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] fi1(input logic [31:0] k);
    return 5'(k % 20);
  endfunction
  function automatic logic [4:0] fi2(input logic [31:0] k);
    return 5'((k / 20) % 20);
  endfunction
  function automatic bit fh1(input logic [31:0] k);
    return t1f[fi1(k)] && t1m[fi1(k)] == k;
  endfunction
  function automatic bit fh2(input logic [31:0] k);
    return t2f[fi2(k)] && t2m[fi2(k)] == k;
  endfunction

  // model: a lookup is busy from acceptance, answers 2 or 3 edges later, then waits for out_ready
  bit          m_busy = 0, m_hit = 0, m_tab = 0;
  int          m_age = 0, m_lat = 0;
  logic [31:0] m_key = 0;
  logic [4:0]  m_a1 = 0, m_a2 = 0, m_idx = 0;
  logic [15:0] m_l = 0, m_h = 0;
  wire         m_valid = m_busy && m_age == m_lat;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_age <= 0; m_lat <= 0; m_key <= 0; m_hit <= 0; m_tab <= 0;
      m_idx <= 0; m_a1 <= 0; m_a2 <= 0; m_l <= 0; m_h <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1; m_age <= 0; m_key <= in_key;
        m_hit  <= fh1(in_key) || fh2(in_key);
        m_tab  <= !fh1(in_key) && fh2(in_key);
        m_idx  <= fh1(in_key) ? fi1(in_key) : fh2(in_key) ? fi2(in_key) : 5'd0;
        m_lat  <= fh1(in_key) ? 2 : 3;
      end
    end else if (m_age < m_lat) begin
      m_age <= m_age + 1;
      if (m_age == 0) begin
        m_a1 <= fi1(m_key);
        m_a2 <= fi2(m_key);
      end
    end else if (out_ready) begin
      m_busy <= 0;
      m_l    <= (m_l == 16'hFFFF) ? m_l : m_l + 1;
      m_h    <= (m_hit && m_h != 16'hFFFF) ? m_h + 1 : m_h;
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("in_ready", 32'(in_ready), 32'(!m_busy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("t1_addr", 32'(t1_addr), 32'(m_a1));
    chk("t2_addr", 32'(t2_addr), 32'(m_a2));
    chk("lookup_cnt", 32'(lookup_cnt), 32'(m_l));
    chk("hit_cnt", 32'(hit_cnt), 32'(m_h));
    if (m_valid) begin
      chk("out_key", out_key, m_key);
      chk("out_hit", 32'(out_hit), 32'(m_hit));
      chk("out_table", 32'(out_table), 32'(m_tab));
      chk("out_index", 32'(out_index), 32'(m_idx));
    end
  end

  task automatic lookup(input logic [31:0] key, input int lat, input logic [4:0] a1,
                        input logic [4:0] a2, input bit hit, input bit tab,
                        input logic [4:0] idx, input int hold);
    int n;
    @(negedge clk); in_valid = 1; in_key = key; out_ready = 0;
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    chk("lit_t1_addr", 32'(t1_addr), 32'(a1));
    chk("lit_t2_addr", 32'(t2_addr), 32'(a2));
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk); n++;
    end
    chk("lit_latency", n, lat);
    chk("lit_hit", 32'(out_hit), 32'(hit));
    chk("lit_table", 32'(out_table), 32'(tab));
    chk("lit_index", 32'(out_index), 32'(idx));
    chk("lit_key", out_key, key);
    repeat (hold) @(negedge clk);
    out_ready = 1;
    @(negedge clk); out_ready = 0;
    chk("lit_in_ready_after", 32'(in_ready), 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      t1m[i] = 0; t2m[i] = 0; t1f[i] = 0; t2f[i] = 0;
    end
    t1m[10] = 50; t1f[10] = 1;
    t2m[3]  = 61; t2f[3]  = 1;
    t1m[4]  = 14; t1f[4]  = 1;
    t2m[2]  = 44;
    t1m[2]  = 82; t1f[2]  = 1;
    chk("lit_fi1_max", 32'(fi1(32'hFFFFFFFF)), 15);
    chk("lit_fi2_max", 32'(fi2(32'hFFFFFFFF)), 4);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_addr", 32'({t1_addr, t2_addr}), 0);
    chk("rst_cnt", 32'({lookup_cnt, hit_cnt}), 0);
    chk_on = 1;
    lookup(32'd50, 2, 5'd10, 5'd2, 1, 0, 5'd10, 0);
    chk("lit_cnt_a", 32'({lookup_cnt, hit_cnt}), {16'd1, 16'd1});
    lookup(32'd61, 3, 5'd1, 5'd3, 1, 1, 5'd3, 0);
    lookup(32'd44, 3, 5'd4, 5'd2, 0, 0, 5'd0, 1);
    chk("lit_cnt_b", 32'({lookup_cnt, hit_cnt}), {16'd3, 16'd2});
    lookup(32'hFFFFFFFF, 3, 5'd15, 5'd4, 0, 0, 5'd0, 0);
    lookup(32'd82, 2, 5'd2, 5'd4, 1, 0, 5'd2, 5);
    chk("lit_cnt_c", 32'({lookup_cnt, hit_cnt}), {16'd5, 16'd3});
    @(negedge clk); in_valid = 1; in_key = 32'd61;
    @(negedge clk); in_valid = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_addr", 32'({t1_addr, t2_addr}), 0);
    chk("mid_rst_cnt", 32'({lookup_cnt, hit_cnt}), 0);
    lookup(32'd50, 2, 5'd10, 5'd2, 1, 0, 5'd10, 2);
    chk("lit_cnt_d", 32'({lookup_cnt, hit_cnt}), {16'd1, 16'd1});
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
